// File: rtl/card_pkg.sv
// card_pkg: shared deck constants, card field types, shoe states and index-to-card decoding.
package card_pkg;
    localparam int DECK_SIZE = 52;
    localparam int RANKS = 13;
    typedef logic [5:0] card_idx_t;
    typedef logic [3:0] rank_t;
    typedef logic [1:0] suit_t;
    typedef enum logic [1:0] {INIT, SHUFFLE, READY, DEAL} shoe_state_t;
    function automatic rank_t idx_to_rank(input card_idx_t idx);
        return rank_t'(idx % card_idx_t'(RANKS)) + rank_t'(1);
    endfunction
    function automatic suit_t idx_to_suit(input card_idx_t idx);
        return suit_t'(idx / card_idx_t'(RANKS));
    endfunction
endpackage

// File: rtl/card_shoe_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (mask 16'hB400), loaded with seed during reset.
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clk) begin
        if (!reset) q <= seed;
        else q <= q[0] ? (q >> 1) ^ 16'hB400 : q >> 1;
    end
endmodule

// File: rtl/card_shoe.sv
// card_shoe: 52-card shoe with Fisher-Yates shuffle; define CARD_SHOE_RESHUFFLE_EN to reshuffle automatically at RESHUFFLE_LEVEL cards left.
module card_shoe
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int RESHUFFLE_LEVEL = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shuffle,
    input  logic       draw_card,
    output logic [3:0] card_value,
    output logic [1:0] card_suit,
    output logic [5:0] card_index,
    output logic       card_valid,
    output logic       ready,
    output logic       empty,
    output logic [5:0] cards_left
);
`ifdef CARD_SHOE_RESHUFFLE_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif
    localparam card_idx_t RELOAD_AT = card_idx_t'(RESHUFFLE_LEVEL + 1);
    shoe_state_t state;
    card_idx_t deck [DECK_SIZE];
    card_idx_t fill, i, pointer, j, top;
    logic [15:0] rnd;
    logic draw_q, pending, draw_edge;
    logic unused_rnd;
    lfsr16 rng (
        .clk(clk),
        .reset(reset),
        .seed(SEED),
        .q(rnd)
    );
    assign j = rnd[5:0];
    assign unused_rnd = ^rnd[15:6];
    assign top = deck[pointer];
    assign draw_edge = draw_card & ~draw_q;
    assign empty = cards_left == '0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= INIT;
            fill <= '0;
            i <= '0;
            pointer <= '0;
            cards_left <= '0;
            pending <= 1'b0;
            draw_q <= 1'b0;
            card_valid <= 1'b0;
            card_value <= '0;
            card_suit <= '0;
            card_index <= '0;
            ready <= 1'b0;
        end else begin
            draw_q <= draw_card;
            card_valid <= 1'b0;
            // Edges arriving while not idle are remembered once and served on READY entry.
            if (draw_edge && (shuffle || state != READY)) pending <= 1'b1;
            if (shuffle) begin
                state <= INIT;
                fill <= '0;
                pointer <= '0;
                cards_left <= '0;
                ready <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        deck[fill] <= fill;
                        fill <= fill + 1'b1;
                        if (fill == card_idx_t'(DECK_SIZE - 1)) begin
                            state <= SHUFFLE;
                            i <= card_idx_t'(DECK_SIZE - 1);
                        end
                    end
                    SHUFFLE: begin
                        // Out-of-range candidates are rejected so every permutation stays equally likely.
                        if (j <= i) begin
                            deck[i] <= deck[j];
                            deck[j] <= deck[i];
                            if (i == card_idx_t'(1)) begin
                                state <= READY;
                                ready <= 1'b1;
                                pointer <= '0;
                                cards_left <= card_idx_t'(DECK_SIZE);
                            end else begin
                                i <= i - 1'b1;
                            end
                        end
                    end
                    READY: begin
                        if (draw_edge || pending) begin
                            pending <= 1'b0;
                            if (!empty) begin
                                state <= DEAL;
                                ready <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        card_index <= top;
                        card_value <= idx_to_rank(top);
                        card_suit <= idx_to_suit(top);
                        card_valid <= 1'b1;
                        pointer <= pointer + 1'b1;
                        cards_left <= cards_left - 1'b1;
                        if (AUTO && cards_left == RELOAD_AT) begin
                            state <= INIT;
                            fill <= '0;
                        end else begin
                            state <= READY;
                            ready <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed, table-driven self-checking bench for card_shoe.
module tb_card_shoe;
    localparam int OP_DRAW = 0;
    localparam int OP_SHUF = 1;
    localparam int OP_IDLE = 2;
    typedef struct {
        int   op;
        int   dv;
        int   left;
        logic emp;
        logic rdy;
    } step_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic shuffle = 1'b0;
    logic draw_card = 1'b0;
    logic [3:0] card_value;
    logic [1:0] card_suit;
    logic [5:0] card_index;
    logic card_valid, ready, empty;
    logic [5:0] cards_left;
    int total = 0;
    int bad = 0;
    int vlog[$];
    always #5 clk = ~clk;
    card_shoe #(.SEED(16'hACE1), .RESHUFFLE_LEVEL(15)) dut (
        .clk(clk),
        .reset(reset),
        .shuffle(shuffle),
        .draw_card(draw_card),
        .card_value(card_value),
        .card_suit(card_suit),
        .card_index(card_index),
        .card_valid(card_valid),
        .ready(ready),
        .empty(empty),
        .cards_left(cards_left)
    );
    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction
    always @(negedge clk) begin
        if (reset && card_valid) begin
            chk("index_range", int'(card_index) < 52, 1);
            chk("card_value", card_value, int'(card_index) % 13 + 1);
            chk("card_suit", card_suit, int'(card_index) / 13);
            vlog.push_back(int'(card_index));
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        reset = 1'b0;
        shuffle = 1'b0;
        draw_card = 1'b0;
        cyc(3);
        chk("rst_ready", ready, 0);
        chk("rst_empty", empty, 1);
        chk("rst_cards_left", cards_left, 0);
        chk("rst_card_valid", card_valid, 0);
        reset = 1'b1;
    endtask
    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (!ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask
    task automatic draw(input logic exp);
        draw_card = 1'b1;
        @(negedge clk);
        draw_card = 1'b0;
        chk("latency_cycle1", card_valid, 0);
        @(negedge clk);
        chk("latency_cycle2", card_valid, exp);
        @(negedge clk);
        chk("strobe_width", card_valid, 0);
        @(negedge clk);
    endtask
    task automatic pulse_shuffle();
        shuffle = 1'b1;
        cyc(1);
        shuffle = 0;
    endtask
    initial begin
        step_t steps[8];
        int n, n0, c0;
        int seen[52];
        int rank_cnt[13];
        steps[0] = '{OP_DRAW, 0, 0, 1'b1, 1'b1};
        steps[1] = '{OP_IDLE, 0, 0, 1'b1, 1'b1};
        steps[2] = '{OP_SHUF, 0, 52, 1'b0, 1'b1};
        steps[3] = '{OP_DRAW, 1, 51, 1'b0, 1'b1};
        steps[4] = '{OP_DRAW, 1, 50, 1'b0, 1'b1};
        steps[5] = '{OP_SHUF, 0, 52, 1'b0, 1'b1};
        steps[6] = '{OP_IDLE, 0, 52, 1'b0, 1'b1};
        steps[7] = '{OP_DRAW, 1, 51, 1'b0, 1'b1};
        do_reset();
        chk("init_not_ready", ready, 0);
        wait_ready(2100, n0);
        chk("init_min_cycles", int'(n0 >= 103), 1);
        chk("ready_cards_left", cards_left, 52);
        chk("ready_empty", empty, 0);
`ifdef CARD_SHOE_RESHUFFLE_EN
        for (int k = 0; k < 37; k++) draw(1'b1);
        chk("auto_reshuffle_not_ready", ready, 0);
        chk("auto_reshuffle_cards", vlog.size(), 37);
        wait_ready(2100, n);
        chk("auto_reshuffle_min_cycles", int'(n >= 99), 1);
        chk("auto_reshuffle_left", cards_left, 52);
`else
        for (int k = 0; k < 52; k++) begin
            draw(1'b1);
            chk("deal_cards_left", cards_left, 51 - k);
        end
        chk("deal_empty", empty, 1);
        chk("deal_count", vlog.size(), 52);
        foreach (seen[k]) seen[k] = 0;
        foreach (rank_cnt[k]) rank_cnt[k] = 0;
        foreach (vlog[k]) begin
            if (vlog[k] >= 0 && vlog[k] < 52) begin
                seen[vlog[k]]++;
                rank_cnt[vlog[k] % 13]++;
            end
        end
        foreach (seen[k]) chk("index_once", seen[k], 1);
        foreach (rank_cnt[k]) chk("rank_four", rank_cnt[k], 4);
        for (int s = 0; s < 8; s++) begin
            c0 = vlog.size();
            if (steps[s].op == OP_DRAW) draw(steps[s].dv != 0);
            else if (steps[s].op == OP_SHUF) begin
                pulse_shuffle();
                chk("tbl_shuffle_clears", cards_left, 0);
                wait_ready(2100, n);
                cyc(4);
            end else cyc(8);
            chk("tbl_new_cards", vlog.size() - c0, steps[s].dv);
            chk("tbl_cards_left", cards_left, steps[s].left);
            chk("tbl_empty", empty, steps[s].emp);
            chk("tbl_ready", ready, steps[s].rdy);
        end
        pulse_shuffle();
        cyc(60);
        chk("busy_not_ready", ready, 0);
        draw_card = 1'b1;
        cyc(1);
        draw_card = 1'b0;
        cyc(3);
        draw_card = 1'b1;
        cyc(1);
        draw_card = 1'b0;
        c0 = vlog.size();
        wait_ready(2100, n);
        chk("pending_not_early", vlog.size() - c0, 0);
        @(negedge clk);
        chk("pending_cycle1", card_valid, 0);
        @(negedge clk);
        chk("pending_cycle2", card_valid, 1);
        cyc(10);
        chk("pending_single", vlog.size() - c0, 1);
        chk("pending_cards_left", cards_left, 51);
        do_reset();
        wait_ready(2100, n);
        chk("repeat_ready_cycles", n, n0);
        c0 = vlog.size();
        for (int k = 0; k < 8; k++) draw(1'b1);
        for (int k = 0; k < 8; k++) chk("repeat_sequence", vlog[c0 + k], vlog[k]);
        pulse_shuffle();
        cyc(70);
        chk("mid_shuffle_busy", ready, 0);
        c0 = vlog.size();
        pulse_shuffle();
        wait_ready(2100, n);
        chk("restart_min_cycles", int'(n >= 102), 1);
        chk("restart_no_card", vlog.size() - c0, 0);
        chk("restart_cards_left", cards_left, 52);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
